// File: rtl/neander_x_datapath.sv
// NEANDER-X register/ALU datapath: PC, REM, RDM, RI, AC, N/Z flags, memory and I/O port drive.
// Latency: every register updates one clk after its strobe; mem_addr/mem_wdata/mem_we are combinational.
// Backpressure: none; the control unit sequences all strobes. Optional NEANDER_X_CARRY_EN adds flagC.
module neander_x_datapath #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic              ac_load,
  input  logic              ri_load,
  input  logic              rem_load,
  input  logic              rdm_load,
  input  logic              nz_load,
  input  logic              addr_sel_pc,
  input  logic [1:0]        alu_op,
  input  logic              io_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [3:0]        opcode,
  output logic              flagN,
  output logic              flagZ,
`ifdef NEANDER_X_CARRY_EN
  output logic              flagC,
`endif
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] io_port,
  output logic              io_strobe
);

  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hE;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] rdm;
  logic [DATA_W-1:0] ri;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ac_src;
  logic [DATA_W-1:0] ac_next;
  logic              src_mem;
  logic              src_in;
`ifdef NEANDER_X_CARRY_EN
  logic              alu_carry;
`endif

  // mem_read is informational only and RI's low bits carry the operand nibble, unused here
  logic unused_ok;
  assign unused_ok = ^{mem_read, ri[DATA_W-5:0]};

  assign opcode    = ri[DATA_W-1 -: 4];
  assign mem_addr  = rem;
  assign mem_wdata = ac;
  assign mem_we    = mem_write;

  assign src_mem = (opcode == OP_LDA) || (opcode == OP_LDI);
  assign src_in  = (opcode == OP_IN);

  // ALU: A is always AC, B is always the memory read data; NOT ignores B
  always_comb begin
    alu_res = '0;
`ifdef NEANDER_X_CARRY_EN
    alu_carry = 1'b0;
`endif
    case (alu_op)
`ifdef NEANDER_X_CARRY_EN
      ALU_ADD: {alu_carry, alu_res} = {1'b0, ac} + {1'b0, mem_rdata};
`else
      ALU_ADD: alu_res = ac + mem_rdata;
`endif
      ALU_AND: alu_res = ac & mem_rdata;
      ALU_OR:  alu_res = ac | mem_rdata;
      default: alu_res = ~ac;
    endcase
  end

  // AC source mux by opcode; ACnext falls back to current AC so N/Z can be refreshed alone
  always_comb begin
    ac_src = alu_res;
    if (src_mem)
      ac_src = mem_rdata;
    else if (src_in)
      ac_src = io_in;
    ac_next = ac_load ? ac_src : ac;
  end

  // PC: load has priority over increment; increment wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= '0;
    else if (pc_load)
      pc <= rdm;
    else if (pc_inc)
      pc <= pc + 1'b1;
  end

  // REM, RDM, RI address/instruction path; REM sees PC before this edge's update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      rdm <= '0;
      ri  <= '0;
    end else begin
      if (rem_load)
        rem <= addr_sel_pc ? pc : rdm;
      if (rdm_load)
        rdm <= mem_rdata;
      if (ri_load)
        ri <= rdm;
    end
  end

  // Accumulator and N/Z flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac    <= '0;
      flagN <= 1'b0;
      flagZ <= 1'b1;
    end else begin
      if (ac_load)
        ac <= ac_next;
      if (nz_load) begin
        flagN <= ac_next[DATA_W-1];
        flagZ <= (ac_next == '0);
      end
    end
  end

`ifdef NEANDER_X_CARRY_EN
  // Carry: set from ADD, cleared by logic ops, held when AC comes from memory or the input port
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flagC <= 1'b0;
    else if (nz_load && !src_mem && !src_in)
      flagC <= (alu_op == ALU_ADD) ? alu_carry : 1'b0;
  end
`endif

  // Output port: data and port number latched together, strobe trails io_write by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out    <= '0;
      io_port   <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= io_write;
      if (io_write) begin
        io_out  <= ac;
        io_port <= rdm;
      end
    end
  end

endmodule

// File: tb/tb_neander_x_datapath.sv
// Directed bench for neander_x_datapath: expectations queued at stimulus time, checked after the edge.
// Inputs change 1 time unit after posedge; outputs are sampled there, away from the active edge.
// Reset behaviour, fetch, ALU ops, flags, PC wrap/priority and I/O port are exercised in order.
module tb_neander_x_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load;
  logic       rem_load, rdm_load, nz_load, addr_sel_pc, io_write;
  logic [1:0] alu_op;
  logic [7:0] mem_rdata, io_in;
  logic [7:0] mem_addr, mem_wdata, io_out, io_port;
  logic       mem_we, flagN, flagZ, io_strobe;
  logic [3:0] opcode;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  string      tag_q [$];

  always #5 clk = ~clk;

  neander_x_datapath #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .pc_inc(pc_inc), .pc_load(pc_load), .ac_load(ac_load), .ri_load(ri_load),
    .rem_load(rem_load), .rdm_load(rdm_load), .nz_load(nz_load),
    .addr_sel_pc(addr_sel_pc), .alu_op(alu_op), .io_write(io_write),
    .mem_rdata(mem_rdata), .io_in(io_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .opcode(opcode),
    .flagN(flagN), .flagZ(flagZ), .io_out(io_out), .io_port(io_port),
    .io_strobe(io_strobe)
  );

  task automatic clear();
    mem_read = 0; mem_write = 0; pc_inc = 0; pc_load = 0; ac_load = 0;
    ri_load = 0; rem_load = 0; rdm_load = 0; nz_load = 0; addr_sel_pc = 0;
    io_write = 0; alu_op = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic push(input string t, input logic [7:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop(input logic [7:0] obs);
    string t;
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // ALU op with B taken from memory at the current REM
  task automatic alu(input logic [1:0] op, input logic [7:0] b);
    mem[mem_addr] = b;
    alu_op = op; ac_load = 1; nz_load = 1;
    step();
  endtask

  task automatic load_rdm(input logic [7:0] v);
    mem[mem_addr] = v;
    rdm_load = 1;
    step();
  endtask

  task automatic show_pc(input string t, input logic [7:0] e);
    push(t, e);
    rem_load = 1; addr_sel_pc = 1;
    step();
    pop(mem_addr);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h30;
    io_in = 8'h00;
    clear();
    reset = 1;
    #12 reset = 0;

    // Dirty the state, then assert reset between edges
    alu_op = 2'b11; ac_load = 1; nz_load = 1;
    rem_load = 1; addr_sel_pc = 1; pc_inc = 1; rdm_load = 1;
    step();
    ri_load = 1; io_write = 1;
    step();
    push("pre_strobe", 8'h01);   pop({7'b0, io_strobe});
    push("pre_ac", 8'hFF);       pop(mem_wdata);
    push("pre_opcode", 8'h03);   pop({4'b0, opcode});
    #2 reset = 1;
    #1;
    push("rst_ac", 8'h00);       pop(mem_wdata);
    push("rst_rem", 8'h00);      pop(mem_addr);
    push("rst_opcode", 8'h00);   pop({4'b0, opcode});
    push("rst_n", 8'h00);        pop({7'b0, flagN});
    push("rst_z", 8'h01);        pop({7'b0, flagZ});
    push("rst_strobe", 8'h00);   pop({7'b0, io_strobe});
    push("rst_io_out", 8'h00);   pop(io_out);
    push("rst_io_port", 8'h00);  pop(io_port);
    #1 reset = 0;

    // Fetch from address 0
    push("fetch_addr", 8'h00);
    rem_load = 1; addr_sel_pc = 1; pc_inc = 1;
    step();
    pop(mem_addr);
    rdm_load = 1;
    step();
    push("fetch_opcode", 8'h03);
    ri_load = 1;
    step();
    pop({4'b0, opcode});
    show_pc("fetch_pc", 8'h01);

    // ADD with flags
    push("add_7f", 8'h7F);       alu(2'b00, 8'h7F); pop(mem_wdata);
    push("add_80", 8'h80);       alu(2'b00, 8'h01); pop(mem_wdata);
    push("add_80_n", 8'h01);     pop({7'b0, flagN});
    push("add_80_z", 8'h00);     pop({7'b0, flagZ});
    push("add_wrap", 8'h00);     alu(2'b00, 8'h80); pop(mem_wdata);
    push("add_wrap_z", 8'h01);   pop({7'b0, flagZ});
    push("add_wrap_n", 8'h00);   pop({7'b0, flagN});

    // Logic ops
    push("ld_f0", 8'hF0);        alu(2'b00, 8'hF0); pop(mem_wdata);
    push("and", 8'h30);          alu(2'b01, 8'h3C); pop(mem_wdata);
    push("or", 8'h3F);           alu(2'b10, 8'h0F); pop(mem_wdata);
    push("not", 8'hC0);          alu(2'b11, 8'hAA); pop(mem_wdata);
    push("not_n", 8'h01);        pop({7'b0, flagN});

    // PC load, wrap, REM-before-PC ordering, load priority
    load_rdm(8'hFF);
    pc_load = 1;
    step();
    pc_inc = 1;
    show_pc("rem_old_pc", 8'hFF);
    show_pc("pc_wrap", 8'h00);
    load_rdm(8'h42);
    pc_inc = 1; pc_load = 1;
    step();
    show_pc("pc_prio", 8'h42);

    // Memory write enable is combinational
    mem_write = 1;
    #1;
    push("mem_we", 8'h01);       pop({7'b0, mem_we});
    clear();

    // OUT
    alu(2'b01, 8'h00);
    push("ac_55", 8'h55);        alu(2'b00, 8'h55); pop(mem_wdata);
    load_rdm(8'h02);
    io_write = 1;
    step();
    push("out_data", 8'h55);     pop(io_out);
    push("out_port", 8'h02);     pop(io_port);
    push("out_strobe", 8'h01);   pop({7'b0, io_strobe});
    step();
    push("out_strobe_off", 8'h00); pop({7'b0, io_strobe});

    // IN
    load_rdm(8'hC0);
    ri_load = 1;
    step();
    push("in_opcode", 8'h0C);    pop({4'b0, opcode});
    io_in = 8'h9A;
    push("in_9a", 8'h9A);        alu(2'b00, 8'h11); pop(mem_wdata);
    push("in_9a_n", 8'h01);      pop({7'b0, flagN});
    io_in = 8'h00;
    push("in_zero", 8'h00);      alu(2'b00, 8'h11); pop(mem_wdata);
    push("in_zero_z", 8'h01);    pop({7'b0, flagZ});
    push("in_zero_n", 8'h00);    pop({7'b0, flagN});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neander_x_datapath.md
# neander_x_datapath

Register-and-ALU datapath for the NEANDER-X CPU. It holds PC, REM, RDM, RI, AC and the N/Z flags. It executes the one-hot-style control strobes issued each cycle by the control unit, and drives the memory address/write-data bus and the output port. It returns `opcode` and the flags to the control unit, closing the fetch/decode/execute loop.

## Interface
Parameters:
- `DATA_W`, 8 — width of AC, RDM, PC, REM and the memory data path; the opcode is always `RI[DATA_W-1 -: 4]`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `mem_read`  in  1  qualifies `mem_rdata` (informational; loads are gated by the `*_load` strobes)
- `mem_write`  in  1  write AC to memory at REM this cycle
- `pc_inc`  in  1  PC <= PC+1
- `pc_load`  in  1  PC <= RDM
- `ac_load`  in  1  AC <= AC-source mux
- `ri_load`  in  1  RI <= RDM
- `rem_load`  in  1  REM <= `addr_sel_pc` ? PC : RDM
- `rdm_load`  in  1  RDM <= `mem_rdata`
- `nz_load`  in  1  update N/Z from the value written to AC
- `addr_sel_pc`  in  1  REM source select
- `alu_op`  in  2  00 ADD, 01 AND, 10 OR, 11 NOT
- `io_write`  in  1  latch AC onto the output port
- `mem_rdata`  in  DATA_W  combinational memory read data for address `mem_addr`
- `io_in`  in  DATA_W  input port value
- `mem_addr`  out  DATA_W  equals REM
- `mem_wdata`  out  DATA_W  equals AC
- `mem_we`  out  1  equals `mem_write`
- `opcode`  out  4  RI upper nibble
- `flagN`, `flagZ`  out  1  registered flags
- `io_out`  out  DATA_W  registered output port
- `io_port`  out  DATA_W  port number, registered from RDM on `io_write`
- `io_strobe`  out  1  one-cycle pulse on the cycle after `io_write`

## Operation
- All registers update on the posedge of `clk`. Reset values: PC, REM, RDM, RI, AC, `io_out`, `io_port` = 0; `flagN` = 0; `flagZ` = 1; `io_strobe` = 0.
- PC priority: `pc_load` overrides `pc_inc`. Increment wraps from 0xFF to 0x00.
- REM samples PC before any same-cycle PC update.
- AC source, decoded from the current `opcode`:
  - 0x2 (LDA) and 0xE (LDI): `mem_rdata`
  - 0xC (IN): `io_in`
  - 0x3, 0x4, 0x5, 0x6: ALU result per `alu_op`, with A=AC and B=`mem_rdata`
  - any other opcode: ALU result
- ADD is modulo 2^DATA_W and the carry is discarded (see Configuration). NOT ignores B.
- When `nz_load` is set: N <= ACnext[MSB] and Z <= (ACnext==0), where ACnext is the value being loaded. If `ac_load` is 0 in that cycle, ACnext is the current AC.
- `mem_we`, `mem_addr` and `mem_wdata` are combinational from the current registers. There is no write/read hazard logic; sequencing is the control unit's responsibility.
- `io_write`: `io_out` <= AC, `io_port` <= RDM, `io_strobe` <= 1 for exactly one cycle. Back-to-back `io_write` keeps `io_strobe` high and updates the data every cycle.
- All strobes in one cycle act independently, except the PC priority above.

## Timing
- Fetch: cycle 1 `rem_load` puts PC on `mem_addr` at cycle 2. Cycle 2 `rdm_load` captures `mem_rdata`. Cycle 3 `ri_load` makes `opcode` valid at cycle 4 (DECODE).
- AC, flags and PC are visible one cycle after their strobe.
- `io_strobe` lags `io_write` by one cycle; it is aligned with valid `io_out`.
- Asserting `reset` mid-instruction clears all state on the same edge, without waiting for a clock. `io_strobe` drops immediately.

## Configuration
- `NEANDER_X_CARRY_EN` defined:
  - adds port `flagC`  out  1 (reset 0).
  - On `nz_load` with `alu_op`=00 and a ALU-sourced AC, C <= carry-out of the add. For AND/OR/NOT, C <= 0. For LDA, LDI and IN, C holds.
- Undefined: no `flagC` port and no carry logic.

## Test plan
- Reset mid-fetch, then release: every register reads 0, `flagZ`=1 and `io_strobe`=0, with no clock edge required.
- Fetch: memory[0]=0x30 (ADD). After fetch, `opcode`=3 and PC=1, and `mem_addr` tracks REM through the sequence.
- AC=0x7F, ADD with `mem_rdata`=0x01: AC=0x80, N=1, Z=0. With the macro, C=0. Then ADD 0x80: AC=0x00, Z=1, and C=1 with the macro.
- AND/OR/NOT: AC=0xF0 with B=0x3C gives AND→0x30, then OR 0x0F→0x3F, then NOT→0xC0 with N=1.
- PC=0xFF with `pc_inc` gives 0x00. `pc_inc` and `pc_load` together with RDM=0x42 gives PC=0x42.
- OUT: AC=0x55, RDM=0x02, `io_write` pulsed → next cycle `io_out`=0x55, `io_port`=0x02, `io_strobe`=1 for one cycle. IN with `io_in`=0x00 gives AC=0, Z=1.
